// File: rtl/tdma_arbiter_if.sv
// Request/ack bundle shared by the low and high domains of tdma_arbiter.
interface tdma_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             l_req;
  logic [1:0]       l_op;
  logic [WIDTH-1:0] l_data;
  logic             l_ack;
  logic [WIDTH-1:0] l_rdata;
  logic             h_req;
  logic [1:0]       h_op;
  logic [WIDTH-1:0] h_data;
  logic             h_ack;
  logic [WIDTH-1:0] h_rdata;
  logic             slot_h;

  modport master (
    output l_req, l_op, l_data, h_req, h_op, h_data,
    input  l_ack, l_rdata, h_ack, h_rdata, slot_h
  );

  modport slave (
    input  l_req, l_op, l_data, h_req, h_op, h_data,
    output l_ack, l_rdata, h_ack, h_rdata, slot_h
  );
endinterface

// File: rtl/tdma_arbiter.sv
// Fixed-schedule TDMA arbiter: L slot, H slot, one scrub cycle, sharing one accumulator.
module tdma_arbiter #(
  parameter int unsigned SLOT_LEN = 4,
  parameter int unsigned WIDTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  tdma_arbiter_if.slave bus
);
  localparam int unsigned CW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLOT_LEN - 1);

  typedef enum logic [1:0] {L_SLOT, H_SLOT, SCRUB} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             l_ack_q, l_ack_d;
  logic             h_ack_q, h_ack_d;
  logic [WIDTH-1:0] l_rdata_q, l_rdata_d;
  logic [WIDTH-1:0] h_rdata_q, h_rdata_d;

  function automatic logic [WIDTH-1:0] alu(input logic [WIDTH-1:0] a,
                                           input logic [1:0]       op,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = a;
    unique case (op)
      2'b00: r = a;
      2'b01: r = a + b;
      2'b10: r = a - b;
      2'b11: r = '0;
      default: r = a;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    l_ack_d   = 1'b0;
    h_ack_d   = 1'b0;
    l_rdata_d = l_rdata_q;
    h_rdata_d = h_rdata_q;
    unique case (state_q)
      L_SLOT: begin
        if (bus.l_req) begin
          acc_d     = alu(acc_q, bus.l_op, bus.l_data);
          l_ack_d   = 1'b1;
          l_rdata_d = acc_d;
        end
        if (cnt_q == LAST) begin
          state_d = H_SLOT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      H_SLOT: begin
        if (bus.h_req) begin
          acc_d     = alu(acc_q, bus.h_op, bus.h_data);
          h_ack_d   = 1'b1;
          h_rdata_d = acc_d;
        end
        if (cnt_q == LAST) begin
          state_d = SCRUB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SCRUB: begin
        // Wiping acc here means every L slot starts from zero, so L results never see H data.
        acc_d     = '0;
        h_rdata_d = '0;
        state_d   = L_SLOT;
        cnt_d     = '0;
      end
      default: begin
        state_d = L_SLOT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= L_SLOT;
      cnt_q     <= '0;
      acc_q     <= '0;
      l_ack_q   <= 1'b0;
      h_ack_q   <= 1'b0;
      l_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      l_ack_q   <= l_ack_d;
      h_ack_q   <= h_ack_d;
      l_rdata_q <= l_rdata_d;
      h_rdata_q <= h_rdata_d;
    end
  end

  assign bus.l_ack   = l_ack_q;
  assign bus.h_ack   = h_ack_q;
  assign bus.l_rdata = l_rdata_q;
  assign bus.h_rdata = h_rdata_q;
  assign bus.slot_h  = (state_q != L_SLOT);
endmodule

// File: tb/tb_tdma_arbiter.sv
// Scoreboard bench for tdma_arbiter: driver queues expected acks, negedge monitor checks them.
module tb_tdma_arbiter;
  localparam int W  = 4;
  localparam int SL = 4;
  localparam logic [1:0] RD = 2'b00, ADD = 2'b01, SUB = 2'b10, CLR = 2'b11;

  typedef struct {
    int e;
    int d;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  tdma_arbiter_if #(.WIDTH(W)) bus();

  tdma_arbiter #(.SLOT_LEN(SL), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   tests = 0, fails = 0, ecnt = 0, ph = 0;
  exp_t lq[$], hq[$];
  bit   armed = 0, slot_exp = 0, h_chk = 1;
  int   l_rd_m = 0, h_rd_m = 0;
  int   tr_mode = 0, tr_idx = 0, m_mode = 0, m_idx = 0;
  logic [5:0] trace [20];

  bit         nr [18] = '{1,1,0,1,0,0,0,0,0, 1,1,0,1,0,0,0,0,0};
  logic [1:0] no [18] = '{ADD,ADD,RD,SUB,RD,RD,RD,RD,RD, RD,SUB,RD,ADD,RD,RD,RD,RD,RD};
  logic [3:0] nd [18] = '{7,10,0,2,0,0,0,0,0, 0,4,0,4,0,0,0,0,0};
  int         ne [18] = '{7,1,-1,15,-1,-1,-1,-1,-1, 0,12,-1,0,-1,-1,-1,-1,-1};

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge clk) begin
    if (armed) begin
      tests++;
      if (bus.slot_h !== slot_exp) begin
        fails++;
        $display("FAIL slot_h edge %0d: got %b want %b", ecnt, bus.slot_h, slot_exp);
      end
      tests++;
      if (lq.size() > 0 && lq[0].e == ecnt) begin
        if (bus.l_ack !== 1'b1 || bus.l_rdata !== lq[0].d[W-1:0]) begin
          fails++;
          $display("FAIL l_ack edge %0d: got ack=%b rdata=%0d want ack=1 rdata=%0d",
                   ecnt, bus.l_ack, bus.l_rdata, lq[0].d);
        end
        void'(lq.pop_front());
      end else if (bus.l_ack !== 1'b0) begin
        fails++;
        $display("FAIL l_ack_idle edge %0d: got %b want 0", ecnt, bus.l_ack);
      end
      tests++;
      if (bus.l_rdata !== l_rd_m[W-1:0]) begin
        fails++;
        $display("FAIL l_rdata edge %0d: got %0d want %0d", ecnt, bus.l_rdata, l_rd_m);
      end
      if (h_chk) begin
        tests++;
        if (hq.size() > 0 && hq[0].e == ecnt) begin
          if (bus.h_ack !== 1'b1 || bus.h_rdata !== hq[0].d[W-1:0]) begin
            fails++;
            $display("FAIL h_ack edge %0d: got ack=%b rdata=%0d want ack=1 rdata=%0d",
                     ecnt, bus.h_ack, bus.h_rdata, hq[0].d);
          end
          void'(hq.pop_front());
        end else if (bus.h_ack !== 1'b0) begin
          fails++;
          $display("FAIL h_ack_idle edge %0d: got %b want 0", ecnt, bus.h_ack);
        end
        tests++;
        if (bus.h_rdata !== h_rd_m[W-1:0]) begin
          fails++;
          $display("FAIL h_rdata edge %0d: got %0d want %0d", ecnt, bus.h_rdata, h_rd_m);
        end
      end
      if (m_mode == 1) begin
        trace[m_idx] = {bus.slot_h, bus.l_ack, bus.l_rdata};
      end else if (m_mode == 2) begin
        tests++;
        if (trace[m_idx] !== {bus.slot_h, bus.l_ack, bus.l_rdata}) begin
          fails++;
          $display("FAIL noninterf step %0d: got %b want %b", m_idx,
                   {bus.slot_h, bus.l_ack, bus.l_rdata}, trace[m_idx]);
        end
      end
    end
  end

  // One clock edge of stimulus; le/he are the hand-computed rdata values (-1: no ack expected).
  task automatic cyc(input bit r, input bit lr, input logic [1:0] lo, input logic [3:0] ld,
                     input bit hr, input logic [1:0] ho, input logic [3:0] hd,
                     input int le, input int he);
    @(negedge clk);
    #1;
    reset = r;
    bus.l_req = lr; bus.l_op = lo; bus.l_data = ld;
    bus.h_req = hr; bus.h_op = ho; bus.h_data = hd;
    if (le >= 0) lq.push_back('{ecnt + 1, le});
    if (he >= 0 && h_chk) hq.push_back('{ecnt + 1, he});
    if (r) begin
      slot_exp = 1'b0; ph = 0; l_rd_m = 0; h_rd_m = 0;
    end else begin
      slot_exp = (ph >= SL - 1 && ph <= 2 * SL - 1);
      if (le >= 0) l_rd_m = le;
      if (he >= 0) h_rd_m = he;
      if (ph == 2 * SL) h_rd_m = 0;
      ph = (ph + 1) % (2 * SL + 1);
    end
    m_mode = tr_mode;
    m_idx  = tr_idx;
    armed  = 1'b1;
  endtask

  task automatic L(input logic [1:0] o, input logic [3:0] d, input int e);
    cyc(1'b0, 1'b1, o, d, 1'b0, RD, 4'd0, e, -1);
  endtask

  task automatic H(input logic [1:0] o, input logic [3:0] d, input int e);
    cyc(1'b0, 1'b0, RD, 4'd0, 1'b1, o, d, -1, e);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, RD, 4'd0, 1'b0, RD, 4'd0, -1, -1);
  endtask

  initial begin
    bus.l_req = 1'b0; bus.l_op = RD; bus.l_data = '0;
    bus.h_req = 1'b0; bus.h_op = RD; bus.h_data = '0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, ADD, 4'd3, 1'b1, ADD, 4'd3, -1, -1);
    // period 1: back-to-back adds, last-cycle request, carry-over into H, scrub
    cyc(1'b0, 1'b1, ADD, 4'd3, 1'b1, ADD, 4'd6, 3, -1);
    L(ADD, 4'd5, 8);
    L(RD, 4'd0, 8);
    L(SUB, 4'd1, 7);
    cyc(1'b0, 1'b1, ADD, 4'd2, 1'b1, ADD, 4'd2, -1, 9);
    H(RD, 4'd0, 9);
    idle();
    H(SUB, 4'd3, 6);
    cyc(1'b0, 1'b1, ADD, 4'd1, 1'b1, ADD, 4'd1, -1, -1);
    // period 2: scrubbed acc, wrap in both directions
    L(RD, 4'd0, 0);
    L(SUB, 4'd1, 15);
    L(ADD, 4'd2, 1);
    L(ADD, 4'd14, 15);
    H(ADD, 4'd1, 0);
    H(ADD, 4'd9, 9);
    H(CLR, 4'd0, 0);
    H(ADD, 4'd4, 4);
    idle();
    // period 3: clear, then reset mid-H with a live request
    L(ADD, 4'd6, 6);
    idle();
    L(CLR, 4'd5, 0);
    idle();
    H(ADD, 4'd5, 5);
    cyc(1'b1, 1'b0, RD, 4'd0, 1'b1, ADD, 4'd3, -1, -1);
    L(RD, 4'd0, 0);
    idle();
    // two runs, same L stimulus, random H stimulus
    h_chk = 1'b0;
    for (int run = 0; run < 2; run++) begin
      tr_mode = run + 1;
      tr_idx  = 0;
      cyc(1'b1, 1'b0, RD, 4'd0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)), -1, -1);
      for (int i = 0; i < 18; i++) begin
        tr_idx = i + 1;
        cyc(1'b0, nr[i], no[i], nd[i], 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), ne[i], -1);
      end
    end
    tr_mode = 0;
    idle();
    idle();
    @(negedge clk);
    #2;
    tests++;
    if (lq.size() != 0 || hq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending acks want 0/0", lq.size(), hq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tdma_arbiter.md
TDMA_ARBITER -- requirements
Module: tdma_arbiter

Interface
REQ-001 Parameter: SLOT_LEN, default 4, cycles per requester slot (SHALL be >= 1).
REQ-002 Parameter: WIDTH, default 4, shared accumulator and data width.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: l_req  input  1  low-domain request; sampled only during L slot.
REQ-006 Port: l_op  input  2  low-domain op: 00 read, 01 add, 10 sub, 11 clear.
REQ-007 Port: l_data  input  WIDTH  low-domain operand.
REQ-008 Port: l_ack  output  1  low-domain completion pulse.
REQ-009 Port: l_rdata  output  WIDTH  accumulator value after the low-domain op.
REQ-010 Port: h_req, h_op, h_data  input  1/2/WIDTH  high-domain equivalents of l_req, l_op, l_data.
REQ-011 Port: h_ack, h_rdata  output  1/WIDTH  high-domain equivalents of l_ack, l_rdata.
REQ-012 Port: slot_h  output  1  1 during H_SLOT and SCRUB, 0 during L_SLOT.

Function
REQ-013 FSM states: L_SLOT, H_SLOT, SCRUB; slot counter cnt, range 0..SLOT_LEN-1.
REQ-014 L_SLOT: cnt increments each cycle; at cnt==SLOT_LEN-1 -> H_SLOT, cnt<=0.
REQ-015 H_SLOT: cnt increments each cycle; at cnt==SLOT_LEN-1 -> SCRUB, cnt<=0.
REQ-016 SCRUB lasts exactly 1 cycle, then -> L_SLOT.
REQ-017 Schedule period is exactly 2*SLOT_LEN+1 cycles; state, cnt and slot_h SHALL depend on reset only, never on any request input.
REQ-018 In L_SLOT with l_req=1: acc updates at that edge (read: unchanged; add: acc+l_data; sub: acc-l_data; clear: 0). l_ack<=1 and l_rdata<=the new acc at the same edge, so both are visible the next cycle.
REQ-019 In H_SLOT with h_req=1: same as REQ-018 using h_op/h_data, driving h_ack/h_rdata.
REQ-020 Add and sub wrap modulo 2^WIDTH; there is no carry, borrow or saturation.
REQ-021 One op per cycle; a request at a slot's last cycle SHALL complete; its ack appears in the first cycle of the next state.
REQ-022 Requests outside their own slot are ignored, not queued. The ack is 0 in every cycle not immediately following an accepted request.
REQ-023 l_ack is a single-cycle pulse per accepted request; back-to-back requests give consecutive ack cycles.
REQ-024 l_ack and l_rdata SHALL be functions only of reset and l_* inputs, never of h_* inputs.
REQ-025 L_SLOT->H_SLOT transition: acc carries over unchanged (upward flow permitted).
REQ-026 SCRUB: acc<=0 and h_rdata<=0; no acks; all requests ignored.
REQ-027 l_rdata holds its value outside L slot acks; h_rdata holds except per REQ-026.

Reset
REQ-028 On reset=1 at an edge: state<=L_SLOT, cnt<=0, acc<=0, l_ack<=0, h_ack<=0, l_rdata<=0, h_rdata<=0, so slot_h=0.
REQ-029 Reset overrides any in-flight op; no ack SHALL follow a request sampled in a reset cycle.
REQ-030 Reset held for N cycles keeps all outputs at reset values; the schedule starts at the first edge with reset=0.

Verification
REQ-031 Idle after reset, SLOT_LEN=4 -> slot_h trace 0,0,0,0,1,1,1,1,1 repeating with period 9.
REQ-032 L slot: l_req add 3 then add 5 on consecutive cycles -> l_ack high 2 cycles, l_rdata 3 then 8.
REQ-033 Wrap: acc=15, L add 2 -> l_rdata=1; acc=0, L sub 1 -> l_rdata=15.
REQ-034 Scrub: H add 9 in H slot (h_rdata=9); next L slot L read -> l_rdata=0, and h_rdata=0 after SCRUB.
REQ-035 Noninterference: two runs, identical reset/l_* stimulus, random differing h_* -> cycle-identical l_ack, l_rdata, slot_h.
REQ-036 Reset asserted mid-H_SLOT with h_req=1 -> next cycle slot_h=0, h_ack=0, all rdata 0; first L read returns 0.
